// File: rtl/fdsti_min_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fdsti_min_sched
//  Purpose  : Drains the per-FDSSI source FIFOs into the per-FDSTI target
//             FIFOs. Every cycle it picks the source head with the smallest
//             FDSTI (ties go to the lowest source index). It re-tags that
//             entry with its source index and pushes it to the target FIFO
//             addressed by the low FDSTI bits. One drain pass runs per
//             in_finish pulse, and done pulses when the pass is complete.
//  Ports    : clk, rst (sync, active-high)
//             in_finish                         start a drain pass (IDLE only)
//             addr_valid/addr_ready/addr        source FIFO heads / pops
//             m_addr_valid/m_addr_ready/m_addr  target FIFO pushes
//             busy, done, moved_cnt, range_err  status
//  Macro    : FDSTI_RANGE_CHECK_EN - drop popped entries whose FDSTI does not
//             address a target, and flag them in sticky range_err.
//  Revision : 1.0  initial release
// ============================================================================
module fdsti_min_sched #(
    parameter int O_SAM_WIDTH   = 2,
    parameter int O_TAM_WIDTH   = 2,
    parameter int I_FDSTI_WIDTH = 28,
    parameter int I_FDSSI_WIDTH = 12,
    parameter int AWIDTH        = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    in_finish,
    input  logic [(2**O_SAM_WIDTH)-1:0]                             addr_valid,
    output logic [(2**O_SAM_WIDTH)-1:0]                             addr_ready,
    input  logic [(2**O_SAM_WIDTH)*(I_FDSTI_WIDTH+2*AWIDTH)-1:0]    addr,
    output logic [(2**O_TAM_WIDTH)-1:0]                             m_addr_valid,
    input  logic [(2**O_TAM_WIDTH)-1:0]                             m_addr_ready,
    output logic [(2**O_TAM_WIDTH)*(I_FDSSI_WIDTH+2*AWIDTH)-1:0]    m_addr,
    output logic                                                    busy,
    output logic                                                    done,
    output logic [CNT_WIDTH-1:0]                                    moved_cnt,
    output logic                                                    range_err
);

    localparam int NS = 2**O_SAM_WIDTH;
    localparam int IW = I_FDSTI_WIDTH + 2*AWIDTH;
    localparam int OW = I_FDSSI_WIDTH + 2*AWIDTH;
    localparam int PW = 2*AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Minimum-FDSTI selection across valid heads
    logic [O_SAM_WIDTH-1:0]   sel_idx;
    logic [I_FDSTI_WIDTH-1:0] sel_key;
    logic [PW-1:0]            sel_pay;
    logic                     any_v;

    // Single-entry output register
    logic                     ovld;
    logic [O_TAM_WIDTH-1:0]   odst;
    logic [OW-1:0]            odata;

    logic                     is_run;
    logic                     drain;
    logic                     pop;
    logic                     key_ok;
    logic                     accept;
    logic [I_FDSSI_WIDTH-1:0] fdssi_ext;

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        sel_idx = '0;
        sel_key = '0;
        sel_pay = '0;
        any_v   = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (addr_valid[i] &&
                (!any_v || (addr[i*IW+PW +: I_FDSTI_WIDTH] < sel_key))) begin
                any_v   = 1'b1;
                sel_idx = O_SAM_WIDTH'(i);
                sel_key = addr[i*IW+PW +: I_FDSTI_WIDTH];
                sel_pay = addr[i*IW +: PW];
            end
        end
    end

    assign is_run = (state == S_RUN);
    assign drain  = ovld & m_addr_ready[odst];
    // Popping in the same cycle as the drain refills the register without a bubble.
    assign pop    = is_run & any_v & (~ovld | drain);

`ifdef FDSTI_RANGE_CHECK_EN
    assign key_ok = ((sel_key >> O_TAM_WIDTH) == '0);
`else
    assign key_ok = 1'b1;
`endif
    // An out-of-range entry is still popped so that the pass can finish.
    assign accept = pop & key_ok;

    always_comb begin
        fdssi_ext                  = '0;
        fdssi_ext[O_SAM_WIDTH-1:0] = sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ovld      <= 1'b0;
            odst      <= '0;
            odata     <= '0;
            moved_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ovld  <= 1'b1;
                odst  <= sel_key[O_TAM_WIDTH-1:0];
                odata <= {fdssi_ext, sel_pay};
            end else if (drain) begin
                ovld  <= 1'b0;
            end
            if ((state == S_IDLE) && in_finish) begin
                moved_cnt <= '0;
            end else if (drain) begin
                moved_cnt <= moved_cnt + 1'b1;
            end
        end
    end

`ifdef FDSTI_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (pop && !key_ok) begin
            range_err <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
`endif

    // The pass ends once every source is empty and the held entry has left.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_finish) state_nxt = S_RUN;
            S_RUN:   if (!any_v && !ovld) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_comb begin
        addr_ready          = '0;
        addr_ready[sel_idx] = pop;
        m_addr_valid        = '0;
        m_addr_valid[odst]  = ovld;
        m_addr              = '0;
        if (ovld) begin
            m_addr[int'(odst)*OW +: OW] = odata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdsti_min_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fdsti_min_sched
//  Purpose  : Scoreboard bench for fdsti_min_sched. Source FIFOs are modelled
//             as queues. Expected pushes are queued when stimulus is loaded,
//             and they are compared against target pushes in order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fdsti_min_sched;

    localparam int OSW = 2;
    localparam int OTW = 2;
    localparam int FW  = 28;
    localparam int SW  = 12;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int NS  = 2**OSW;
    localparam int ND  = 2**OTW;
    localparam int IW  = FW + 2*AW;
    localparam int OW  = SW + 2*AW;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_finish;
    logic [NS-1:0]      addr_valid;
    logic [NS-1:0]      addr_ready;
    logic [NS*IW-1:0]   addr;
    logic [ND-1:0]      m_addr_valid;
    logic [ND-1:0]      m_addr_ready;
    logic [ND*OW-1:0]   m_addr;
    logic               busy;
    logic               done;
    logic [CW-1:0]      moved_cnt;
    logic               range_err;

    fdsti_min_sched #(
        .O_SAM_WIDTH  (OSW),
        .O_TAM_WIDTH  (OTW),
        .I_FDSTI_WIDTH(FW),
        .I_FDSSI_WIDTH(SW),
        .AWIDTH       (AW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_finish   (in_finish),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .addr        (addr),
        .m_addr_valid(m_addr_valid),
        .m_addr_ready(m_addr_ready),
        .m_addr      (m_addr),
        .busy        (busy),
        .done        (done),
        .moved_cnt   (moved_cnt),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    logic [IW-1:0]     srcq [NS][$];
    logic [OTW+OW-1:0] expq [$];
    logic [NS-1:0]     pop_mask = '0;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                done_cnt = 0;
    int                cur_run  = 0;
    int                max_run  = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] ent(input int fdsti, input logic [AW-1:0] s, input logic [AW-1:0] e);
        return {fdsti[FW-1:0], s, e};
    endfunction

    function automatic logic [OTW+OW-1:0] xp(input int dst, input int fdssi,
                                             input logic [AW-1:0] s, input logic [AW-1:0] e);
        return {dst[OTW-1:0], fdssi[SW-1:0], s, e};
    endfunction

    // Source FIFO model: pops granted at the previous edge, then presents new heads.
    initial begin
        addr_valid = '0;
        addr       = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (pop_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                addr_valid[i] = (srcq[i].size() > 0);
                addr[i*IW +: IW] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
            end
        end
    end

    // Output monitor, sampled mid-cycle after all inputs have settled.
    initial begin
        logic [OTW+OW-1:0] e;
        logic [ND*OW-1:0]  m;
        int                j;
        logic              pushed;
        forever begin
            @(negedge clk);
            #2;
            pop_mask = addr_ready;
            pushed   = 1'b0;
            if (addr_ready != '0) begin
                check_val("pop_onehot", $countones(addr_ready), 1);
                check_val("pop_only_in_run", busy, 1);
            end
            if (m_addr_valid != '0) begin
                check_val("push_onehot", $countones(m_addr_valid), 1);
                j = 0;
                for (int k = 0; k < ND; k++) if (m_addr_valid[k]) j = k;
                m = '0;
                m[j*OW +: OW] = '1;
                check_val("other_slots_zero", |(m_addr & ~m), 0);
                if (m_addr_ready[j]) begin
                    pushed = 1'b1;
                    if (expq.size() == 0) begin
                        check_val("unexpected_push", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check_val("push_dst", j, e[OW +: OTW]);
                        check_val("push_data", m_addr[j*OW +: OW], e[OW-1:0]);
                    end
                end
            end
            if (pushed) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_pass();
        @(negedge clk);
        in_finish = 1'b1;
        @(negedge clk);
        in_finish = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #3;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("done_seen", ok, 1);
    endtask

    task automatic wait_push_valid(input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #3;
            if (m_addr_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("held_entry_seen", ok, 1);
    endtask

    // Expected order: repeatedly take the smallest head FDSTI, lowest source on ties.
    task automatic predict();
        logic [IW-1:0] cq [NS][$];
        int            best;
        logic [IW-1:0] h;
        for (int i = 0; i < NS; i++) cq[i] = srcq[i];
        forever begin
            best = -1;
            for (int i = 0; i < NS; i++) begin
                if (cq[i].size() > 0) begin
                    if (best < 0) best = i;
                    else if (cq[i][0][IW-1 -: FW] < cq[best][0][IW-1 -: FW]) best = i;
                end
            end
            if (best < 0) break;
            h = cq[best].pop_front();
            expq.push_back(xp(int'(h[2*AW +: OTW]), best, h[2*AW-1:AW], h[AW-1:0]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND*OW-1:0] snap;
        rst          = 1'b1;
        in_finish    = 1'b0;
        m_addr_ready = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_moved", moved_cnt, 0);
        check_val("rst_range_err", range_err, 0);
        check_val("rst_addr_ready", addr_ready, 0);
        check_val("rst_m_valid", m_addr_valid, 0);
        check_val("rst_m_addr", |m_addr, 0);

        // Basic ordering; sources are valid before in_finish and must not be popped.
        srcq[0].push_back(ent(2, 32'hA000_0001, 32'hA000_00FF));
        srcq[1].push_back(ent(1, 32'hB000_0002, 32'hB000_00EE));
        expq.push_back(xp(1, 1, 32'hB000_0002, 32'hB000_00EE));
        expq.push_back(xp(2, 0, 32'hA000_0001, 32'hA000_00FF));
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            #3;
            check_val("no_pop_idle", addr_ready, 0);
        end
        start_pass();
        #3;
        check_val("busy_in_run", busy, 1);
        wait_done(30);
        check_val("basic_moved", moved_cnt, 2);
        repeat (3) @(negedge clk);
        #3;
        check_val("basic_done_once", done_cnt, 1);
        check_val("basic_all_pushed", expq.size(), 0);
        check_val("basic_idle", busy, 0);

        // Equal FDSTI: the lower source index wins.
        srcq[3].push_back(ent(0, 32'hC000_0003, 32'hC000_00DD));
        srcq[1].push_back(ent(0, 32'hD000_0004, 32'hD000_00CC));
        expq.push_back(xp(0, 1, 32'hD000_0004, 32'hD000_00CC));
        expq.push_back(xp(0, 3, 32'hC000_0003, 32'hC000_00DD));
        repeat (2) @(negedge clk);
        start_pass();
        wait_done(30);
        check_val("tie_moved", moved_cnt, 2);
        check_val("tie_all_pushed", expq.size(), 0);

        // Backpressure on target 1 for five cycles.
        m_addr_ready = 4'b1101;
        srcq[0].push_back(ent(1, 32'h1111_0000, 32'h1111_00FF));
        srcq[1].push_back(ent(1, 32'h2222_0000, 32'h2222_00FF));
        srcq[2].push_back(ent(3, 32'h3333_0000, 32'h3333_00FF));
        expq.push_back(xp(1, 0, 32'h1111_0000, 32'h1111_00FF));
        expq.push_back(xp(1, 1, 32'h2222_0000, 32'h2222_00FF));
        expq.push_back(xp(3, 2, 32'h3333_0000, 32'h3333_00FF));
        repeat (2) @(negedge clk);
        start_pass();
        wait_push_valid(10);
        snap = m_addr;
        repeat (5) begin
            @(negedge clk);
            #3;
            check_val("bp_valid_held", m_addr_valid, 4'b0010);
            check_val("bp_data_stable", |(m_addr ^ snap), 0);
            check_val("bp_no_pop", addr_ready, 0);
        end
        @(negedge clk);
        m_addr_ready = '1;
        #1;
        check_val("bp_pop_resume", addr_ready, 4'b0010);
        wait_done(30);
        check_val("bp_moved", moved_cnt, 3);
        check_val("bp_all_pushed", expq.size(), 0);

        // Streaming eight entries, plus an in_finish pulse during RUN.
        srcq[0].push_back(ent(3, 32'h0000_0A00, 32'h0000_0A01));
        srcq[0].push_back(ent(0, 32'h0000_0A10, 32'h0000_0A11));
        srcq[1].push_back(ent(1, 32'h0000_0B00, 32'h0000_0B01));
        srcq[1].push_back(ent(1, 32'h0000_0B10, 32'h0000_0B11));
        srcq[2].push_back(ent(2, 32'h0000_0C00, 32'h0000_0C01));
        srcq[2].push_back(ent(0, 32'h0000_0C10, 32'h0000_0C11));
        srcq[3].push_back(ent(0, 32'h0000_0D00, 32'h0000_0D01));
        srcq[3].push_back(ent(3, 32'h0000_0D10, 32'h0000_0D11));
        predict();
        repeat (2) @(negedge clk);
        cur_run  = 0;
        max_run  = 0;
        done_cnt = 0;
        start_pass();
        repeat (2) @(negedge clk);
        in_finish = 1'b1;
        @(negedge clk);
        in_finish = 1'b0;
        wait_done(40);
        check_val("stream_moved", moved_cnt, 8);
        check_val("stream_no_bubble", max_run, 8);
        check_val("stream_all_pushed", expq.size(), 0);
        repeat (3) @(negedge clk);
        #3;
        check_val("finish_in_run_ignored", busy, 0);
        check_val("stream_done_once", done_cnt, 1);

        // FDSTI beyond the target count.
        srcq[0].push_back(ent(7, 32'hE000_0005, 32'hE000_00BB));
`ifndef FDSTI_RANGE_CHECK_EN
        expq.push_back(xp(3, 0, 32'hE000_0005, 32'hE000_00BB));
`endif
        repeat (2) @(negedge clk);
        done_cnt = 0;
        start_pass();
        wait_done(30);
`ifdef FDSTI_RANGE_CHECK_EN
        check_val("range_err_set", range_err, 1);
        check_val("range_moved", moved_cnt, 0);
`else
        check_val("range_err_tied", range_err, 0);
        check_val("range_moved", moved_cnt, 1);
`endif
        check_val("range_all_pushed", expq.size(), 0);
        check_val("range_src_popped", srcq[0].size(), 0);

        // Reset in the middle of RUN while an entry is held.
        m_addr_ready = 4'b1101;
        srcq[0].push_back(ent(1, 32'hF000_0006, 32'hF000_00AA));
        srcq[2].push_back(ent(2, 32'hF100_0006, 32'hF100_00AA));
        repeat (2) @(negedge clk);
        start_pass();
        wait_push_valid(10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NS; i++) srcq[i].delete();
        #3;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_m_valid", m_addr_valid, 0);
        check_val("mid_rst_m_addr", |m_addr, 0);
        check_val("mid_rst_addr_ready", addr_ready, 0);
        check_val("mid_rst_moved", moved_cnt, 0);
        check_val("mid_rst_range_err", range_err, 0);
        m_addr_ready = '1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
